// File: rtl/gmm_out_packer.sv
`default_nettype none
// ============================================================================
// Module      : gmm_out_packer
// Description : Packs 32-bit GMM pixel results into 256-bit RAM words and
//               ping-pongs two 32-word banks with a DMA consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module gmm_out_packer #(
    parameter int PIX_W      = 32,
    parameter int LANES      = 8,
    parameter int ADDR_W     = 6,
    parameter int BANK_WORDS = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PIX_W-1:0]            in_data,
    input  logic                        in_sop,
    input  logic                        in_eop,
    output logic [ADDR_W-1:0]           ram_address,
    output logic                        ram_chipselect,
    output logic                        ram_write,
    output logic [PIX_W*LANES-1:0]      ram_writedata,
    output logic [PIX_W*LANES/8-1:0]    ram_byteenable,
    output logic                        ram_clken,
    output logic                        bank_ready,
    output logic                        bank_id,
    output logic [ADDR_W-1:0]           bank_words,
    output logic                        bank_last,
    input  logic [1:0]                  bank_release,
    output logic                        err_sop
);

    localparam int c_WORD_W    = PIX_W * LANES;
    localparam int c_BE_W      = c_WORD_W / 8;
    localparam int c_PIX_BYTES = PIX_W / 8;
    localparam int c_LANE_W    = $clog2(LANES);
    localparam int c_WIDX_W    = $clog2(BANK_WORDS);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;

    logic [c_LANE_W-1:0]   r_lane_cnt;
    logic [c_WIDX_W-1:0]   r_word_idx;
    logic                  r_cur_bank;
    logic [1:0]            r_owned;
    logic                  r_in_ready;
    logic [c_WORD_W-1:0]   r_asm;
    logic                  r_err_sop;

    logic                  w_accept;
    logic                  w_restart;
    logic [c_LANE_W-1:0]   w_lane;
    logic [c_WIDX_W-1:0]   w_word;
    logic                  w_word_done;
    logic                  w_bank_done;
    logic [c_WORD_W-1:0]   w_asm_next;
    logic [c_BE_W-1:0]     w_be;
    logic [1:0]            w_set;
    logic [1:0]            w_owned_next;
    logic                  w_cur_bank_next;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_accept    = in_valid & r_in_ready;
    assign w_restart   = in_sop & ((r_lane_cnt != '0) | (r_word_idx != '0));
    assign w_lane      = w_restart ? '0 : r_lane_cnt;
    assign w_word      = w_restart ? '0 : r_word_idx;
    assign w_word_done = (w_lane == c_LANE_W'(LANES - 1)) | in_eop;
    assign w_bank_done = w_word_done & ((w_word == c_WIDX_W'(BANK_WORDS - 1)) | in_eop);

    always_comb begin
        w_asm_next = w_restart ? '0 : r_asm;
        w_asm_next[w_lane*PIX_W +: PIX_W] = in_data;
    end

    always_comb begin
        w_be = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i <= int'(w_lane)) begin
                w_be[i*c_PIX_BYTES +: c_PIX_BYTES] = '1;
            end
        end
    end

    // A handover and a release of the same bank in one cycle: handover wins.
    assign w_set           = (w_accept & w_bank_done) ? (r_cur_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_owned_next    = (r_owned & ~bank_release) | w_set;
    assign w_cur_bank_next = r_cur_bank ^ (w_accept & w_bank_done);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lane_cnt <= '0;
            r_word_idx <= '0;
            r_cur_bank <= 1'b0;
            r_owned    <= 2'b00;
            r_in_ready <= 1'b0;
            r_asm      <= '0;
            r_err_sop  <= 1'b0;
        end else begin
            r_owned    <= w_owned_next;
            r_cur_bank <= w_cur_bank_next;
            r_in_ready <= ~w_owned_next[w_cur_bank_next];
            if (w_accept) begin
                r_err_sop <= r_err_sop | w_restart;
                if (w_word_done) begin
                    r_lane_cnt <= '0;
                    r_asm      <= '0;
                    r_word_idx <= w_bank_done ? '0 : w_word + c_WIDX_W'(1);
                end else begin
                    r_lane_cnt <= w_lane + c_LANE_W'(1);
                    r_asm      <= w_asm_next;
                    r_word_idx <= w_word;
                end
            end
        end
    end

    // Completed word leaves through output registers so input never stalls.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            ram_address    <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_writedata  <= '0;
            ram_byteenable <= '0;
            bank_ready     <= 1'b0;
            bank_id        <= 1'b0;
            bank_words     <= '0;
            bank_last      <= 1'b0;
        end else begin
            ram_write      <= 1'b0;
            ram_chipselect <= 1'b0;
            bank_ready     <= 1'b0;
            if (w_accept && w_word_done) begin
                ram_write      <= 1'b1;
                ram_chipselect <= 1'b1;
                ram_address    <= ADDR_W'({r_cur_bank, w_word});
                ram_writedata  <= w_asm_next;
                ram_byteenable <= w_be;
            end
            if (w_accept && w_bank_done) begin
                bank_ready <= 1'b1;
                bank_id    <= r_cur_bank;
                bank_words <= ADDR_W'({1'b0, w_word}) + ADDR_W'(1);
                bank_last  <= in_eop;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign err_sop   = r_err_sop;
    assign ram_clken = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_gmm_out_packer.sv
`default_nettype none
// Scoreboard bench for gmm_out_packer: model pushes expected writes and
// handovers as pixels are driven; a negedge monitor pops and compares.
module tb_gmm_out_packer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_sop;
    logic         in_eop;
    logic [5:0]   ram_address;
    logic         ram_chipselect;
    logic         ram_write;
    logic [255:0] ram_writedata;
    logic [31:0]  ram_byteenable;
    logic         ram_clken;
    logic         bank_ready;
    logic         bank_id;
    logic [5:0]   bank_words;
    logic         bank_last;
    logic [1:0]   bank_release;
    logic         err_sop;

    always #5 clk = ~clk;

    gmm_out_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .ram_clken      (ram_clken),
        .bank_ready     (bank_ready),
        .bank_id        (bank_id),
        .bank_words     (bank_words),
        .bank_last      (bank_last),
        .bank_release   (bank_release),
        .err_sop        (err_sop)
    );

    typedef struct packed {
        logic [5:0]   addr;
        logic [255:0] data;
        logic [31:0]  be;
    } wr_t;

    typedef struct packed {
        logic       id;
        logic [5:0] words;
        logic       last;
    } ho_t;

    wr_t          wr_q[$];
    ho_t          ho_q[$];
    int           checks = 0;
    int           failures = 0;
    int           stall_cycles = 0;
    bit           wr_due = 0;
    bit           ho_due = 0;
    bit           mon_en = 0;
    int           m_lane, m_word;
    logic         m_bank;
    logic [255:0] m_asm;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        ho_t h;
        if (mon_en) begin
            if (ram_write || wr_due) check_eq("wr_timing", ram_write, wr_due);
            if (ram_write) begin
                check_eq("wr_cs", ram_chipselect, 1);
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected", ram_write, 0);
                end else begin
                    e = wr_q.pop_front();
                    check_eq("wr_addr", ram_address, e.addr);
                    check_eq("wr_data", ram_writedata, e.data);
                    check_eq("wr_be", ram_byteenable, e.be);
                end
            end
            if (bank_ready || ho_due) check_eq("ho_timing", bank_ready, ho_due);
            if (bank_ready) begin
                if (ho_q.size() == 0) begin
                    check_eq("ho_unexpected", bank_ready, 0);
                end else begin
                    h = ho_q.pop_front();
                    check_eq("ho_id", bank_id, h.id);
                    check_eq("ho_words", bank_words, h.words);
                    check_eq("ho_last", bank_last, h.last);
                end
            end
            wr_due = 0;
            ho_due = 0;
        end
    end

    task automatic send(input logic [31:0] d, input bit sop, input bit eop);
        logic [32:0] bem;
        wr_t w;
        ho_t h;
        bit  wdone = 0;
        bit  hdone = 0;
        int  n = 0;
        w = '0;
        h = '0;
        if (sop && (m_lane != 0 || m_word != 0)) begin
            m_lane = 0;
            m_word = 0;
            m_asm  = '0;
        end
        m_asm[m_lane*32 +: 32] = d;
        if (m_lane == 7 || eop) begin
            bem    = (33'd1 << (4 * (m_lane + 1))) - 33'd1;
            w.addr = {m_bank, 5'(m_word)};
            w.data = m_asm;
            w.be   = bem[31:0];
            wdone  = 1;
            if (m_word == 31 || eop) begin
                h.id    = m_bank;
                h.words = 6'(m_word + 1);
                h.last  = eop;
                hdone   = 1;
                m_bank  = ~m_bank;
                m_word  = 0;
            end else begin
                m_word++;
            end
            m_lane = 0;
            m_asm  = '0;
        end else begin
            m_lane++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        stall_cycles += n;
        if (!in_ready) check_eq("ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        if (wdone) begin
            wr_q.push_back(w);
            wr_due = 1;
        end
        if (hdone) begin
            ho_q.push_back(h);
            ho_due = 1;
        end
    endtask

    task automatic do_reset();
        int n = 0;
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_sop       = 1'b0;
        in_eop       = 1'b0;
        in_data      = '0;
        bank_release = 2'b00;
        #1;
        wr_q.delete();
        ho_q.delete();
        wr_due = 0;
        ho_due = 0;
        m_lane = 0;
        m_word = 0;
        m_bank = 1'b0;
        m_asm  = '0;
        check_eq("rst_write", ram_write, 0);
        check_eq("rst_cs", ram_chipselect, 0);
        check_eq("rst_outs", {ram_address, ram_byteenable, bank_ready, bank_id, bank_words, bank_last, in_ready}, 0);
        check_eq("rst_wdata", ram_writedata, 0);
        check_eq("rst_clken", ram_clken, 1);
        check_eq("rst_err", err_sop, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_ready_up", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_sop       = 1'b0;
        in_eop       = 1'b0;
        in_data      = '0;
        bank_release = 2'b00;
        repeat (2) @(posedge clk);
        do_reset();
        mon_en = 1;

        // Eight pixels, no eop: one full word at address 0.
        for (int i = 1; i <= 8; i++) send(32'(i), i == 1, 1'b0);
        check_eq("w8_write_now", ram_write, 1);
        check_eq("w8_lane0", ram_writedata[31:0], 32'd1);
        check_eq("w8_lane7", ram_writedata[255:224], 32'd8);

        // 256-pixel frame fills bank 0 exactly, ending on lane 7.
        do_reset();
        stall_cycles = 0;
        for (int i = 0; i < 256; i++) send(32'h1000_0000 + 32'(i), i == 0, i == 255);
        @(negedge clk);
        check_eq("f256_ready", in_ready, 1);
        check_eq("f256_no_stall", stall_cycles, 0);

        // 19-pixel frame: two full words and a 3-lane tail.
        do_reset();
        for (int i = 0; i < 19; i++) send($urandom, i == 0, i == 18);
        @(negedge clk);

        // Fill both banks without release, then free bank 0.
        do_reset();
        for (int i = 0; i < 512; i++) send(32'h2000_0000 + 32'(i), i == 0, 1'b0);
        @(negedge clk);
        check_eq("stall_ready_low", in_ready, 0);
        repeat (3) @(negedge clk);
        bank_release = 2'b10;
        @(negedge clk);
        bank_release = 2'b00;
        check_eq("other_release_low", in_ready, 0);
        @(negedge clk);
        bank_release = 2'b01;
        check_eq("release_cycle_low", in_ready, 0);
        @(negedge clk);
        bank_release = 2'b00;
        check_eq("release_ready_up", in_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send(32'h3000_0000 + 32'(i), 1'b0, 1'b0);

        // sop on the 5th pixel drops the partial word and restarts at lane 0.
        do_reset();
        for (int i = 0; i < 4; i++) send(32'h4000_0000 + 32'(i), i == 0, 1'b0);
        check_eq("sop_err_before", err_sop, 0);
        send(32'h5000_0000, 1'b1, 1'b0);
        check_eq("sop_err_set", err_sop, 1);
        for (int i = 1; i < 8; i++) send(32'h5000_0000 + 32'(i), 1'b0, 1'b0);
        @(negedge clk);
        check_eq("sop_err_sticky", err_sop, 1);

        // Reset while a write is on the port, then a clean word at address 0.
        do_reset();
        for (int i = 0; i < 16; i++) send(32'h6000_0000 + 32'(i), i == 0, 1'b0);
        check_eq("pend_write_high", ram_write, 1);
        do_reset();
        for (int i = 0; i < 8; i++) send(32'h7000_0000 + 32'(i), i == 0, 1'b0);
        repeat (2) @(negedge clk);

        check_eq("wr_q_empty", wr_q.size(), 0);
        check_eq("ho_q_empty", ho_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
